// File: rtl/mult_seq_pkg.sv
// Shared encodings for the iterative multiply sequencer: FSM states and the
// ALU opcode it borrows from the execute-stage ALU.
package mult_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Matches the opcode map of the existing EX-stage ALU.
   localparam logic [2:0] ALU_OP_ADD = 3'b100;

   localparam int MUL_W = 16;

endpackage

// File: rtl/mult_seq_alu_in_mux.sv
// 2:1 bus mux in front of the shared ALU: pipeline controls/operands
// normally, sequencer controls/operands while a multiply iterates.
module mult_seq_alu_in_mux #(
   parameter int WIDTH = 16
) (
   input  logic             sel_seq,
   input  logic [WIDTH-1:0] pipe_oprnd_1,
   input  logic [WIDTH-1:0] pipe_oprnd_2,
   input  logic [2:0]       pipe_alu_op,
   input  logic             pipe_alu_Cin,
   input  logic             pipe_alu_invA,
   input  logic             pipe_alu_invB,
   input  logic             pipe_alu_sign,
   input  logic [WIDTH-1:0] seq_oprnd_1,
   input  logic [WIDTH-1:0] seq_oprnd_2,
   input  logic [2:0]       seq_alu_op,
   input  logic             seq_alu_Cin,
   input  logic             seq_alu_invA,
   input  logic             seq_alu_invB,
   input  logic             seq_alu_sign,
   output logic [WIDTH-1:0] alu_oprnd_1,
   output logic [WIDTH-1:0] alu_oprnd_2,
   output logic [2:0]       alu_op,
   output logic             alu_Cin,
   output logic             alu_invA,
   output logic             alu_invB,
   output logic             alu_sign
);

   always_comb begin
      if (sel_seq) begin
         alu_oprnd_1 = seq_oprnd_1;
         alu_oprnd_2 = seq_oprnd_2;
         alu_op      = seq_alu_op;
         alu_Cin     = seq_alu_Cin;
         alu_invA    = seq_alu_invA;
         alu_invB    = seq_alu_invB;
         alu_sign    = seq_alu_sign;
      end else begin
         alu_oprnd_1 = pipe_oprnd_1;
         alu_oprnd_2 = pipe_oprnd_2;
         alu_op      = pipe_alu_op;
         alu_Cin     = pipe_alu_Cin;
         alu_invA    = pipe_alu_invA;
         alu_invB    = pipe_alu_invB;
         alu_sign    = pipe_alu_sign;
      end
   end

endmodule

// File: rtl/mult_seq.sv
// Shift-add 16x16 multiply sequencer (low 16 product bits) that borrows the
// execute-stage ALU for its additions and stalls the pipeline meanwhile.
module mult_seq
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] mul_a,
   input  logic [WIDTH-1:0] mul_b,
   input  logic [WIDTH-1:0] pipe_oprnd_1,
   input  logic [WIDTH-1:0] pipe_oprnd_2,
   input  logic [2:0]       pipe_alu_op,
   input  logic             pipe_alu_Cin,
   input  logic             pipe_alu_invA,
   input  logic             pipe_alu_invB,
   input  logic             pipe_alu_sign,
   input  logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_oprnd_1,
   output logic [WIDTH-1:0] alu_oprnd_2,
   output logic [2:0]       alu_op,
   output logic             alu_Cin,
   output logic             alu_invA,
   output logic             alu_invB,
   output logic             alu_sign,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             run;
   logic             accept;

   assign accept = (state_q == ST_IDLE) & start & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (mul_b != '0) ? ST_RUN : ST_DONE;
         // Exit once the remaining multiplier bits are all consumed.
         ST_RUN:  if ((b_sh_q >> 1) == '0) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_comb begin
      acc_d    = acc_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      if (accept) begin
         acc_d  = '0;
         a_sh_d = mul_a;
         b_sh_d = mul_b;
      end else if (state_q == ST_RUN) begin
         if (b_sh_q[0]) acc_d = alu_out;
         a_sh_d = a_sh_q << 1;
         b_sh_d = b_sh_q >> 1;
      end
      // Capture on entry to DONE so result is stable for the whole done cycle.
      if (state_d == ST_DONE) result_d = acc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      run   = (state_q == ST_RUN);
      stall = run | accept;
      // A flush landing on the done cycle kills the MUL, so no result is reported.
      done  = (state_q == ST_DONE) & ~flush;
   end

   assign result = result_q;

   mult_seq_alu_in_mux #(.WIDTH(WIDTH)) u_alu_in_mux (
      .sel_seq       (run),
      .pipe_oprnd_1  (pipe_oprnd_1),
      .pipe_oprnd_2  (pipe_oprnd_2),
      .pipe_alu_op   (pipe_alu_op),
      .pipe_alu_Cin  (pipe_alu_Cin),
      .pipe_alu_invA (pipe_alu_invA),
      .pipe_alu_invB (pipe_alu_invB),
      .pipe_alu_sign (pipe_alu_sign),
      .seq_oprnd_1   (acc_q),
      .seq_oprnd_2   (a_sh_q),
      .seq_alu_op    (ALU_OP_ADD),
      .seq_alu_Cin   (1'b0),
      .seq_alu_invA  (1'b0),
      .seq_alu_invB  (1'b0),
      .seq_alu_sign  (1'b0),
      .alu_oprnd_1   (alu_oprnd_1),
      .alu_oprnd_2   (alu_oprnd_2),
      .alu_op        (alu_op),
      .alu_Cin       (alu_Cin),
      .alu_invA      (alu_invA),
      .alu_invB      (alu_invB),
      .alu_sign      (alu_sign)
   );

endmodule
